// File: rtl/cpu_seq_if.sv
// Sequencer-side bundle: decoder results and memory ack in, datapath strobes and status out.
// master drives the decoder/memory side, slave is the sequencer itself.
interface cpu_seq_if;
    logic        run;
    logic        branch_inst;
    logic        data_inst;
    logic        load_inst;
    logic        cond_pass;
    logic        set_flags;
    logic        mem_ack;
    logic        ir_load;
    logic        pc_en;
    logic        pc_sel;
    logic        reg_we;
    logic        flag_we;
    logic        mem_req;
    logic        retire;
    logic        fault;
    logic [2:0]  state;
    logic [31:0] instr_retired;
    logic [31:0] stall_cycles;

    modport master (
        output run, branch_inst, data_inst, load_inst, cond_pass, set_flags, mem_ack,
        input  ir_load, pc_en, pc_sel, reg_we, flag_we, mem_req, retire, fault, state,
               instr_retired, stall_cycles
    );

    modport slave (
        input  run, branch_inst, data_inst, load_inst, cond_pass, set_flags, mem_ack,
        output ir_load, pc_en, pc_sel, reg_we, flag_we, mem_req, retire, fault, state,
               instr_retired, stall_cycles
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the ARM-subset core.
// Define CPU_SEQ_PERF_COUNT_EN to build the retired-instruction and MEM-stall counters.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      reset,
    cpu_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic ir_load, pc_en, pc_sel, reg_we, flag_we, mem_req, retire, fault;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        wait_d  = wait_q;
        ir_load = 1'b0;
        pc_en   = 1'b0;
        pc_sel  = 1'b0;
        reg_we  = 1'b0;
        flag_we = 1'b0;
        mem_req = 1'b0;
        retire  = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (bus.run) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (bus.cond_pass && bus.branch_inst) begin
                    pc_en   = 1'b1;
                    pc_sel  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (bus.cond_pass && bus.load_inst) begin
                    wait_d  = '0;
                    state_d = S_MEM;
                end else if (bus.cond_pass && bus.data_inst) begin
                    state_d = S_WB;
                end else begin
                    // Condition failed or no class decoded: retire as a NOP.
                    pc_en   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                flag_we = bus.data_inst & bus.set_flags;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.ir_load = ir_load;
    assign bus.pc_en   = pc_en;
    assign bus.pc_sel  = pc_sel;
    assign bus.reg_we  = reg_we;
    assign bus.flag_we = flag_we;
    assign bus.mem_req = mem_req;
    assign bus.retire  = retire;
    assign bus.fault   = fault;
    assign bus.state   = state_q;

`ifdef CPU_SEQ_PERF_COUNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire)                retired_q <= retired_q + 32'd1;
            if (mem_req && !bus.mem_ack) stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.instr_retired = retired_q;
    assign bus.stall_cycles  = stall_q;
`else
    assign bus.instr_retired = 32'h0;
    assign bus.stall_cycles  = 32'h0;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed cases plus randomized instruction
// streams checked against a per-instruction cycle model of the sequencing rules.
module tb_cpu_sequencer;
    localparam int MT = 4;

    logic clk = 1'b0;
    logic reset;
    cpu_seq_if bus ();

    cpu_sequencer #(.MEM_TIMEOUT(MT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retired = 0;
    int exp_stalls  = 0;

    // Expected vector: {ir_load, pc_en, pc_sel, reg_we, flag_we, mem_req, retire, fault, state}
    function automatic logic [10:0] ev(bit ir, bit pe, bit ps, bit rw, bit fw, bit mr, bit rt,
                                       bit ft, logic [2:0] st);
        return {ir, pe, ps, rw, fw, mr, rt, ft, st};
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp_v);
        logic [10:0] obs;
        obs = {bus.ir_load, bus.pc_en, bus.pc_sel, bus.reg_we, bus.flag_we, bus.mem_req,
               bus.retire, bus.fault, bus.state};
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_decoder();
        bus.branch_inst = 1'($urandom_range(0, 1));
        bus.data_inst   = 1'($urandom_range(0, 1));
        bus.load_inst   = 1'($urandom_range(0, 1));
        bus.cond_pass   = 1'($urandom_range(0, 1));
        bus.set_flags   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.run     = 1'($urandom_range(0, 1));
        bus.mem_ack = 1'($urandom_range(0, 1));
        tick();
        reset       = 1'b0;
        bus.run     = 1'b0;
        exp_retired = 0;
        exp_stalls  = 0;
    endtask

    task automatic chk_perf(input string tag);
`ifdef CPU_SEQ_PERF_COUNT_EN
        chk32({tag, "_retired"}, bus.instr_retired, 32'(exp_retired));
        chk32({tag, "_stalls"},  bus.stall_cycles,  32'(exp_stalls));
`else
        chk32({tag, "_retired"}, bus.instr_retired, 32'h0);
        chk32({tag, "_stalls"},  bus.stall_cycles,  32'h0);
`endif
    endtask

    // One instruction from its FETCH cycle to retirement (or fault). ack_at is the
    // 1-based MEM cycle on which mem_ack is raised; anything outside 1..MT never acks.
    task automatic do_instr(input bit br, input bit dp, input bit ld, input bit cp, input bit sf,
                            input int ack_at, input int idle, output bit faulted);
        bit skip, is_br, is_ld;
        faulted = 1'b0;
        skip  = !cp || !(br || ld || dp);
        is_br = !skip && br;
        is_ld = !skip && !br && ld;

        for (int i = 0; i < idle; i++) begin
            bus.run = 1'b0;
            noise_decoder();
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
            tick();
        end

        bus.run = 1'b1;
        bus.branch_inst = br;
        bus.data_inst   = dp;
        bus.load_inst   = ld;
        bus.cond_pass   = cp;
        bus.set_flags   = sf;
        bus.mem_ack     = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("fetch", ev(1, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        tick();

        bus.run = 1'($urandom_range(0, 1));
        bus.mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("decode", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick();

        bus.run = 1'($urandom_range(0, 1));
        bus.mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (skip || is_br) begin
            chk("exec_retire", ev(0, 1, is_br, 0, 0, 0, 1, 0, 3'd2));
            tick();
            exp_retired++;
            return;
        end
        chk("exec_wait", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        tick();

        if (is_ld) begin
            for (int k = 1; k <= MT; k++) begin
                bus.run = 1'($urandom_range(0, 1));
                bus.mem_ack = (k == ack_at);
                @(negedge clk);
                chk($sformatf("mem%0d", k), ev(0, 0, 0, 0, 0, 1, 0, 0, 3'd3));
                tick();
                if (k == ack_at) break;
                exp_stalls++;
                if (k == MT) begin
                    faulted = 1'b1;
                    return;
                end
            end
        end

        bus.run = 1'($urandom_range(0, 1));
        bus.mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("wb", ev(0, 1, 0, 1, dp & sf, 0, 1, 0, 3'd4));
        tick();
        exp_retired++;
    endtask

    task automatic fault_hold(input int n);
        for (int i = 0; i < n; i++) begin
            bus.run = 1'($urandom_range(0, 1));
            noise_decoder();
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("fault_hold", ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
            tick();
        end
    endtask

    initial begin
        bit f;
        reset = 1'b1;
        bus.run = 1'b0;
        bus.branch_inst = 1'b0;
        bus.data_inst = 1'b0;
        bus.load_inst = 1'b0;
        bus.cond_pass = 1'b0;
        bus.set_flags = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        do_reset();
        @(negedge clk);
        chk("reset_state", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        chk_perf("reset");
        tick();

        // Branch, data op with flags, load acked on 3rd MEM cycle, back to back
        do_instr(1, 0, 0, 1, 0, 0, 0, f);
        do_instr(0, 1, 0, 1, 1, 0, 0, f);
        do_instr(0, 0, 1, 1, 0, 3, 0, f);
        chk_perf("seq3");

        do_instr(0, 1, 0, 1, 0, 0, 0, f);   // data op, no S bit
        do_instr(0, 1, 0, 0, 1, 0, 0, f);   // condition failed
        do_instr(0, 0, 0, 1, 1, 0, 1, f);   // no class: NOP
        do_instr(1, 1, 1, 1, 1, 1, 0, f);   // branch wins over load/data
        do_instr(0, 1, 1, 1, 1, 1, 0, f);   // single-cycle MEM, load wins over data
        do_instr(0, 0, 1, 1, 0, MT, 0, f);  // ack on the last allowed MEM cycle
        chk_perf("directed");

        // Timeout: no ack at all
        do_instr(0, 0, 1, 1, 0, 0, 0, f);
        chk32("timeout_flag", 32'(f), 32'd1);
        fault_hold(20);
        chk_perf("fault");
        do_reset();
        @(negedge clk);
        chk("fault_cleared", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        chk_perf("fault_cleared");
        tick();

        // Reset in the middle of MEM
        do_instr(0, 0, 1, 1, 0, 1, 0, f);
        bus.run = 1'b1;
        bus.load_inst = 1'b1;
        bus.cond_pass = 1'b1;
        bus.branch_inst = 1'b0;
        tick();
        tick();
        tick();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("mid_mem", ev(0, 0, 0, 0, 0, 1, 0, 0, 3'd3));
        tick();
        do_reset();
        @(negedge clk);
        chk("mid_mem_reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        chk_perf("mid_mem_reset");
        tick();

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, MT + 1)), int'($urandom_range(0, 2)), f);
            if (f) begin
                fault_hold(3);
                chk_perf("rand_fault");
                do_reset();
            end
        end
        chk_perf("random_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
